imem_loader: RTL and testbench

Write-side counterpart of the fetch path. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words sequentially into instruction memory through a write port, then releases the CPU core reset. It sits between the debug/boot byte source and the instruction memory write port. While loading, it holds the core (PC register and pipeline) in reset so fetch never sees partial contents.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian words from a byte stream into instruction memory while holding the core in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
    localparam state_t LAST_NX = CHECK;
`else
    localparam state_t LAST_NX = DONE;
`endif

    state_t state, state_nx;
    logic [ADDR_W:0]   wc;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        bcnt;
    logic [23:0]       word;
    logic              go, take, last, bad_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xsum;
`endif

    assign go        = start && (state == IDLE || state == DONE);
    assign take      = rx_valid && rx_ready;
    assign last      = ({1'b0, idx} + (ADDR_W+1)'(1)) == wc;
    assign bad_count = word_count == '0 || word_count > CAP;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        im_we    = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE, DONE: state_nx = start ? (bad_count ? DONE : RECV) : state;
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                state_nx = (take && bcnt == 2'd3) ? WRITE : RECV;
            end
            WRITE: begin
                im_we    = 1'b1;
                busy     = 1'b1;
                state_nx = last ? LAST_NX : RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                state_nx = take ? DONE : CHECK;
            end
`endif
            default: state_nx = IDLE;
        endcase
        cpu_reset_n = ~busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc       <= '0;
            idx      <= '0;
            bcnt     <= '0;
            word     <= '0;
            im_addr  <= BASE_ADDR;
            im_wdata <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xsum     <= '0;
`endif
        end else begin
            if (go) begin
                wc   <= word_count;
                idx  <= '0;
                bcnt <= '0;
                done <= word_count == '0;
                err  <= word_count > CAP;
`ifdef LOADER_CHECKSUM_EN
                xsum <= '0;
`endif
            end
            if (state == RECV && take) begin
                bcnt <= bcnt + 2'd1;
                word <= {word[15:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
                xsum <= xsum ^ rx_data;
`endif
                if (bcnt == 2'd3) begin
                    im_wdata <= {word, rx_data};
                    im_addr  <= BASE_ADDR + (32'(idx) << 2);
                end
            end
            // idx stays on the final word so it never runs past the memory size
            if (state == WRITE) idx <= last ? idx : idx + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            if (state == CHECK && take) begin
                done <= rx_data == xsum;
                err  <= rx_data != xsum;
            end
`else
            if (state == WRITE && last) done <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader against a byte-list/word-list model.
module tb_imem_loader;
    localparam int AW = 10;
    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
    logic [AW:0] word_count = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, im_we, cpu_reset_n, busy, done, err;
    logic [31:0] im_addr, im_wdata;
    int tests = 0, fails = 0;
    logic [31:0] wa[$], wd[$];

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (im_we === 1'b1) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end

    initial begin
        #3ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic wq_t words_of(bq_t b);
        wq_t w;
        for (int i = 0; i + 3 < b.size(); i += 4) w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
        return w;
    endfunction

    function automatic bq_t with_csum(bq_t b);
        bq_t r = b;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = '0;
        foreach (b[i]) x ^= b[i];
        r.push_back(x);
`endif
        return r;
    endfunction

    function automatic bq_t rand_bytes(int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_writes(string name, wq_t exp);
        tests++;
        if (wd.size() != exp.size()) begin
            fails++;
            $display("FAIL %s write count got %0d expected %0d", name, wd.size(), exp.size());
        end else
            foreach (exp[i]) begin
                tests++;
                if (wa[i] !== 32'(i * 4) || wd[i] !== exp[i]) begin
                    fails++;
                    $display("FAIL %s write %0d got %h:%h expected %h:%h", name, i, wa[i], wd[i], 32'(i * 4), exp[i]);
                end
            end
    endtask

    task automatic do_start(int wc);
        @(negedge clk);
        start = 1'b1;
        word_count = (AW+1)'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: valid always, 1: toggling, 2: random; off is the stream index of b[0]
    task automatic send(string name, bq_t b, int mode, int off);
        int i = 0, cyc = 0, crn_bad = 0;
        bit pend = 1'b0, ph = 1'b0;
        while (i < b.size() && cyc < 10 * b.size() + 50) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                tests++;
                if (im_we !== 1'b1) begin fails++; $display("FAIL %s write latency im_we got %b expected 1", name, im_we); end
            end
            if (cpu_reset_n !== 1'b0) crn_bad++;
            rx_valid = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(0, 1));
            ph = !ph;
            rx_data = b[i];
            if (rx_valid && rx_ready) begin
                pend = (i + off) % 4 == 3;
                i++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (pend) begin
            tests++;
            if (im_we !== 1'b1) begin fails++; $display("FAIL %s write latency im_we got %b expected 1", name, im_we); end
        end
        tests++;
        if (i != b.size()) begin fails++; $display("FAIL %s stream stalled sent %0d expected %0d", name, i, b.size()); end
        tests++;
        if (crn_bad != 0) begin fails++; $display("FAIL %s cpu_reset_n high for %0d load cycles expected 0", name, crn_bad); end
    endtask

    task automatic wait_idle(string name, logic exp_done, logic exp_err);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s busy timeout got %b expected 0", name, busy); end
        tests++;
        if (done !== exp_done || err !== exp_err || cpu_reset_n !== 1'b1)
            begin fails++; $display("FAIL %s done/err/cpu_reset_n got %b%b%b expected %b%b1", name, done, err, cpu_reset_n, exp_done, exp_err); end
    endtask

    task automatic check_reset_outputs(string name);
        tests++;
        if ({rx_ready, im_we, cpu_reset_n, busy, done, err} !== 6'b001000 || im_addr !== 32'h0 || im_wdata !== 32'h0)
            begin fails++; $display("FAIL %s reset outputs got %b%b%b%b%b%b %h %h expected 001000 0 0", name,
                rx_ready, im_we, cpu_reset_n, busy, done, err, im_addr, im_wdata); end
    endtask

    task automatic run_load(string name, int wc, bq_t b, int mode);
        clear_writes();
        do_start(wc);
        tests++;
        if (cpu_reset_n !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL %s after start cpu_reset_n/busy got %b%b expected 01", name, cpu_reset_n, busy); end
        send(name, with_csum(b), mode, 0);
        wait_idle(name, 1'b1, 1'b0);
        check_writes(name, words_of(b));
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_basic();
        bq_t b = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h09, 8'h12, 8'h34};
        run_load("basic", 2, b, 0);
        check_writes("basic_const", '{32'h24080005, 32'h3C091234});
    endtask

    task automatic test_toggle_valid();
        bq_t b = '{8'h24, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h09, 8'h12, 8'h34};
        run_load("toggle", 2, b, 1);
    endtask

    task automatic test_zero_count();
        clear_writes();
        do_start(0);
        tests++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL zero done/err/busy got %b%b%b expected 100", done, err, busy); end
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (rx_ready !== 1'b0) begin fails++; $display("FAIL zero rx_ready got %b expected 0", rx_ready); end
        end
        rx_valid = 1'b0;
        check_writes("zero", '{});
    endtask

    task automatic test_over_capacity();
        clear_writes();
        do_start((1 << AW) + 1);
        tests++;
        if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL over done/err/busy got %b%b%b expected 010", done, err, busy); end
        repeat (3) @(negedge clk);
        check_writes("over", '{});
    endtask

    task automatic test_full_capacity();
        bq_t b = rand_bytes(4 << AW);
        run_load("full", 1 << AW, b, 0);
    endtask

    task automatic test_reset_mid_load();
        bq_t b = rand_bytes(8);
        bq_t part = b[0:5];
        bq_t b2 = rand_bytes(4);
        wq_t w = words_of(b);
        clear_writes();
        do_start(2);
        send("midreset", part, 0, 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check_writes("midreset", '{w[0]});
        @(negedge clk);
        reset = 1'b1;
        run_load("after_reset", 1, b2, 0);
    endtask

    task automatic test_restart_ignored();
        bq_t b = rand_bytes(8);
        bq_t full = with_csum(b);
        bq_t head = full[0:1];
        bq_t rest = full[2:$];
        clear_writes();
        do_start(2);
        send("restart", head, 0, 0);
        @(negedge clk);
        start = 1'b1;
        word_count = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL restart busy/done got %b%b expected 10", busy, done); end
        send("restart", rest, 0, 2);
        wait_idle("restart", 1'b1, 1'b0);
        check_writes("restart", words_of(b));
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int wc = $urandom_range(1, 5);
            run_load($sformatf("random%0d", k), wc, rand_bytes(4 * wc), 2);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bq_t good = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        bq_t bad  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        clear_writes();
        do_start(1);
        send("csum_good", good, 0, 0);
        wait_idle("csum_good", 1'b1, 1'b0);
        check_writes("csum_good", '{32'h01020304});
        clear_writes();
        do_start(1);
        send("csum_bad", bad, 0, 0);
        wait_idle("csum_bad", 1'b0, 1'b1);
        check_writes("csum_bad", '{32'h01020304});
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_zero_count();
        test_over_capacity();
        test_reset_mid_load();
        test_restart_ignored();
        test_random();
        test_full_capacity();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
